// File: rtl/alu_flag_unit.sv
// 6502-style ALU stage feeding the status register: one operation per start pulse,
// registered result plus next C/Z/N/V, with an extra cycle for BCD ADC/SBC adjust.
module alu_flag_unit #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op_sel,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             decimal_in,
    input  logic             carry_cur,
    input  logic             zero_cur,
    input  logic             negative_cur,
    input  logic             overflow_cur,
    output logic             busy,
    output logic             done,
    output logic             flags_load,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero_out,
    output logic             negative_out,
    output logic             overflow_out
);

    localparam int MSB = WIDTH - 1;

    localparam logic [OP_W-1:0] OP_ADC = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SBC = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ORA = OP_W'(3);
    localparam logic [OP_W-1:0] OP_EOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ASL = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LSR = OP_W'(6);
    localparam logic [OP_W-1:0] OP_ROL = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ROR = OP_W'(8);
    localparam logic [OP_W-1:0] OP_INC = OP_W'(9);
    localparam logic [OP_W-1:0] OP_DEC = OP_W'(10);
    localparam logic [OP_W-1:0] OP_CMP = OP_W'(11);
    localparam logic [OP_W-1:0] OP_BIT = OP_W'(12);

    typedef enum logic {IDLE, ADJUST} state_t;
    state_t state;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   cmp_diff;
    logic             nib_carry;
    logic             add_v;
    logic             bcd_start;
    logic [WIDTH-1:0] bin_result;
    logic             bin_c, bin_z, bin_n, bin_v, keep_zn;

    // Binary path: everything that completes at the start edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        addend     = (op_sel == OP_SBC) ? ~operand_b : operand_b;
        sum_ext    = {1'b0, operand_a} + {1'b0, addend} + (WIDTH+1)'(carry_cur);
        // Carry into bit 4 recovered from the sum without a separate nibble adder.
        nib_carry  = sum_ext[4] ^ operand_a[4] ^ addend[4];
        add_v      = (operand_a[MSB] == addend[MSB]) && (sum_ext[MSB] != operand_a[MSB]);
        cmp_diff   = {1'b0, operand_a} - {1'b0, operand_b};
        bcd_start  = decimal_in && ((op_sel == OP_ADC) || (op_sel == OP_SBC));
        bin_result = operand_a;
        bin_c      = carry_cur;
        bin_v      = overflow_cur;
        keep_zn    = 1'b0;
        case (op_sel)
            OP_ADC, OP_SBC: begin
                bin_result = sum_ext[MSB:0];
                bin_c      = sum_ext[WIDTH];
                bin_v      = add_v;
            end
            OP_AND: bin_result = operand_a & operand_b;
            OP_ORA: bin_result = operand_a | operand_b;
            OP_EOR: bin_result = operand_a ^ operand_b;
            OP_ASL: begin
                bin_result = {operand_a[MSB-1:0], 1'b0};
                bin_c      = operand_a[MSB];
            end
            OP_LSR: begin
                bin_result = {1'b0, operand_a[MSB:1]};
                bin_c      = operand_a[0];
            end
            OP_ROL: begin
                bin_result = {operand_a[MSB-1:0], carry_cur};
                bin_c      = operand_a[MSB];
            end
            OP_ROR: begin
                bin_result = {carry_cur, operand_a[MSB:1]};
                bin_c      = operand_a[0];
            end
            OP_INC: bin_result = operand_a + WIDTH'(1);
            OP_DEC: bin_result = operand_a - WIDTH'(1);
            OP_CMP: begin
                bin_result = cmp_diff[MSB:0];
                bin_c      = ~cmp_diff[WIDTH];
            end
            OP_BIT: begin
                bin_result = operand_a & operand_b;
                bin_v      = operand_b[MSB-1];
            end
            default: keep_zn = 1'b1;
        endcase
        bin_z = keep_zn ? zero_cur : (bin_result == '0);
        bin_n = keep_zn ? negative_cur
                        : ((op_sel == OP_BIT) ? operand_b[MSB] : bin_result[MSB]);
    end

    // Operation state carried into the decimal-adjust cycle.
    logic [WIDTH:0]   bcd_sum;
    logic             bcd_hc;
    logic             bcd_sub;
    logic             bcd_v;

    logic [WIDTH+1:0] adc_adj;
    logic             adc_hi;
    logic [WIDTH-1:0] adc_res;
    logic [WIDTH-1:0] sbc_res;
    logic [WIDTH-1:0] adj_result;
    logic             adj_c;

    always_comb begin
        adc_adj = {1'b0, bcd_sum};
        if ((adc_adj[3:0] > 4'd9) || bcd_hc)
            adc_adj = adc_adj + (WIDTH+2)'(6);
        // High-part test is made after the low-nibble correction.
        adc_hi  = bcd_sum[WIDTH] || (adc_adj > (WIDTH+2)'('h9F));
        adc_res = adc_hi ? (adc_adj[MSB:0] + WIDTH'('h60)) : adc_adj[MSB:0];

        sbc_res = bcd_sum[MSB:0];
        if (!bcd_hc)
            sbc_res = sbc_res - WIDTH'(6);
        if (!bcd_sum[WIDTH])
            sbc_res = sbc_res - WIDTH'('h60);

        adj_result = bcd_sub ? sbc_res : adc_res;
        adj_c      = bcd_sub ? bcd_sum[WIDTH] : adc_hi;
    end

    // NOTE: sequential state uses non-blocking assignments only; all registers here are plain flops, so all take the async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            flags_load   <= 1'b0;
            result       <= '0;
            carry_out    <= 1'b0;
            zero_out     <= 1'b0;
            negative_out <= 1'b0;
            overflow_out <= 1'b0;
            bcd_sum      <= '0;
            bcd_hc       <= 1'b0;
            bcd_sub      <= 1'b0;
            bcd_v        <= 1'b0;
        end else begin
            done       <= 1'b0;
            flags_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bcd_start) begin
                            state   <= ADJUST;
                            busy    <= 1'b1;
                            bcd_sum <= sum_ext;
                            bcd_hc  <= nib_carry;
                            bcd_sub <= (op_sel == OP_SBC);
                            bcd_v   <= add_v;
                        end else begin
                            result       <= bin_result;
                            carry_out    <= bin_c;
                            zero_out     <= bin_z;
                            negative_out <= bin_n;
                            overflow_out <= bin_v;
                            done         <= 1'b1;
                            flags_load   <= 1'b1;
                        end
                    end
                end
                ADJUST: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    result       <= adj_result;
                    carry_out    <= adj_c;
                    zero_out     <= (adj_result == '0);
                    negative_out <= adj_result[MSB];
                    overflow_out <= bcd_v;
                    done         <= 1'b1;
                    flags_load   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: directed corner cases plus random ops
// compared against a decimal/integer reference model.
module tb_alu_flag_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] op_sel;
    logic [7:0] operand_a, operand_b;
    logic       decimal_in, carry_cur, zero_cur, negative_cur, overflow_cur;
    logic       busy, done, flags_load;
    logic [7:0] result;
    logic       carry_out, zero_out, negative_out, overflow_out;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] r;
        logic       c, z, n, v;
    } exp_t;

    alu_flag_unit #(.WIDTH(8), .OP_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_sel(op_sel),
        .operand_a(operand_a), .operand_b(operand_b), .decimal_in(decimal_in),
        .carry_cur(carry_cur), .zero_cur(zero_cur), .negative_cur(negative_cur),
        .overflow_cur(overflow_cur), .busy(busy), .done(done), .flags_load(flags_load),
        .result(result), .carry_out(carry_out), .zero_out(zero_out),
        .negative_out(negative_out), .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int bcd2int(input int x);
        return (x / 16) * 10 + (x % 16);
    endfunction

    function automatic int int2bcd(input int x);
        return ((x / 10) * 16) + (x % 10);
    endfunction

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic bit ovf(input int s);
        return (s > 127) || (s < -128);
    endfunction

    // Reference model: plain integer and decimal arithmetic on the operation rules.
    function automatic exp_t model(input int op, input int a, input int b, input bit d,
                                   input bit c, input bit z, input bit n, input bit v);
        exp_t e;
        int   s;
        int   cin;
        cin = c ? 1 : 0;
        e.r = 8'(a);
        e.c = c;
        e.v = v;
        case (op)
            0: begin
                s   = a + b + cin;
                e.v = ovf(sgn(a) + sgn(b) + cin);
                if (d) begin
                    s   = bcd2int(a) + bcd2int(b) + cin;
                    e.c = (s >= 100);
                    e.r = 8'(int2bcd(s % 100));
                end else begin
                    e.c = (s > 255);
                    e.r = 8'(s);
                end
            end
            1: begin
                s   = a - b - (1 - cin);
                e.v = ovf(sgn(a) - sgn(b) - (1 - cin));
                if (d) begin
                    s   = bcd2int(a) - bcd2int(b) - (1 - cin);
                    e.c = (s >= 0);
                    e.r = 8'(int2bcd((s + 100) % 100));
                end else begin
                    e.c = (s >= 0);
                    e.r = 8'(s);
                end
            end
            2:  e.r = 8'(a & b);
            3:  e.r = 8'(a | b);
            4:  e.r = 8'(a ^ b);
            5:  begin e.r = 8'(a * 2);             e.c = (a >= 128);    end
            6:  begin e.r = 8'(a / 2);             e.c = (a % 2 == 1);  end
            7:  begin e.r = 8'(a * 2 + cin);       e.c = (a >= 128);    end
            8:  begin e.r = 8'(a / 2 + cin * 128); e.c = (a % 2 == 1);  end
            9:  e.r = 8'(a + 1);
            10: e.r = 8'(a + 255);
            11: begin e.r = 8'(a - b + 256);       e.c = (a >= b);      end
            12: begin e.r = 8'(a & b);             e.v = ((b / 64) % 2 == 1); end
            default: ;
        endcase
        e.z = (e.r == 8'h00);
        e.n = (e.r >= 8'h80);
        if (op == 12) begin
            e.z = ((a & b) == 0);
            e.n = (b >= 128);
        end
        if (op >= 13) begin
            e.z = z;
            e.n = n;
        end
        return e;
    endfunction

    task automatic drive(input int op, input logic [7:0] a, input logic [7:0] b,
                         input bit d, input bit c, input bit z, input bit n, input bit v);
        start        = 1'b1;
        op_sel       = 4'(op);
        operand_a    = a;
        operand_b    = b;
        decimal_in   = d;
        carry_cur    = c;
        zero_cur     = z;
        negative_cur = n;
        overflow_cur = v;
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".done"},  done, 1);
        check({tag, ".load"},  flags_load, 1);
        check({tag, ".busy"},  busy, 0);
        check({tag, ".res"},   result, e.r);
        check({tag, ".c"},     carry_out, e.c);
        check({tag, ".z"},     zero_out, e.z);
        check({tag, ".n"},     negative_out, e.n);
        check({tag, ".v"},     overflow_out, e.v);
    endtask

    // Issues one op at a negedge and checks it through to the cycle after done.
    task automatic run_op(input string tag, input int op, input logic [7:0] a,
                          input logic [7:0] b, input bit d, input bit c, input bit z,
                          input bit n, input bit v);
        exp_t e;
        bit   is_bcd;
        e      = model(op, a, b, d, c, z, n, v);
        is_bcd = d && (op < 2);
        drive(op, a, b, d, c, z, n, v);
        @(negedge clk);
        start = 1'b0;
        if (is_bcd) begin
            check({tag, ".adj_busy"}, busy, 1);
            check({tag, ".adj_done"}, done, 0);
            @(negedge clk);
        end
        check_outputs(tag, e);
        @(negedge clk);
        check({tag, ".pulse"}, done, 0);
    endtask

    initial begin
        exp_t e;
        int   op;
        logic [7:0] a, b;
        bit   d;

        reset_n = 1'b0;
        start   = 1'b0;
        drive(0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        start   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.res",  result, 0);
        check("rst.flags", {carry_out, zero_out, negative_out, overflow_out}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("adc_bin_7f",  0, 8'h7F, 8'h01, 0, 0, 0, 0, 0);
        check("adc_bin_7f.spec", {result, carry_out, zero_out, negative_out, overflow_out},
              {8'h80, 4'b0011});
        run_op("adc_bcd_99",  0, 8'h99, 8'h01, 1, 0, 0, 0, 0);
        check("adc_bcd_99.spec", {result, carry_out, zero_out}, {8'h00, 2'b11});
        run_op("sbc_bcd_42",  1, 8'h42, 8'h15, 1, 1, 0, 0, 0);
        check("sbc_bcd_42.spec", {result, carry_out, zero_out, negative_out},
              {8'h27, 3'b100});
        run_op("and_pass",    2, 8'hF0, 8'h0F, 0, 1, 0, 0, 1);
        check("and_pass.spec", {result, carry_out, zero_out, overflow_out},
              {8'h00, 3'b111});
        run_op("inc_wrap",    9, 8'hFF, 8'h00, 0, 0, 0, 1, 0);
        check("inc_wrap.spec", {result, zero_out}, {8'h00, 1'b1});
        run_op("dec_wrap",   10, 8'h00, 8'h00, 0, 1, 1, 0, 1);
        check("dec_wrap.spec", {result, negative_out}, {8'hFF, 1'b1});
        run_op("bit_op",     12, 8'h0F, 8'hC0, 0, 1, 0, 0, 0);
        run_op("cmp_eq",     11, 8'h33, 8'h33, 0, 0, 0, 1, 1);
        run_op("nop_13",     13, 8'h00, 8'h55, 1, 1, 0, 1, 0);
        run_op("adc_bcd_cc", 0, 8'h58, 8'h46, 1, 1, 0, 0, 0);
        run_op("sbc_bcd_br", 1, 8'h00, 8'h01, 1, 1, 0, 0, 0);

        // Start during ADJUST is dropped; start in the done cycle is accepted.
        drive(0, 8'h99, 8'h01, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("b2b.busy", busy, 1);
        drive(2, 8'hFF, 8'h00, 0, 0, 0, 0, 0);
        @(negedge clk);
        e = model(0, 8'h99, 8'h01, 1, 0, 0, 0, 0);
        check_outputs("b2b.first", e);
        drive(9, 8'h41, 8'h00, 0, 0, 0, 0, 0);
        @(negedge clk);
        start = 1'b0;
        e = model(9, 8'h41, 8'h00, 0, 0, 0, 0, 0);
        check_outputs("b2b.second", e);
        @(negedge clk);
        check("b2b.idle1", done, 0);
        @(negedge clk);
        check("b2b.idle2", done, 0);

        // Reset while in ADJUST aborts without a done pulse.
        drive(0, 8'h45, 8'h45, 1, 0, 0, 0, 0);
        @(negedge clk);
        start   = 1'b0;
        check("rstadj.busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rstadj.outs", {busy, done, flags_load, result, carry_out, zero_out,
              negative_out, overflow_out}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstadj.nodone", {done, busy}, 0);
        end

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 15));
            d  = 1'($urandom_range(0, 1));
            if (d && op < 2) begin
                a = 8'(int2bcd(int'($urandom_range(0, 99))));
                b = 8'(int2bcd(int'($urandom_range(0, 99))));
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, d,
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
